// File: rtl/mcs4_bus_fabric.sv
// ============================================================================
// Module   : mcs4_bus_fabric
// Brief    : Tristate-free MCS-4 data bus fabric. It resolves the bus value with
//            a fixed-priority mux, follows the 8-phase instruction cycle, captures
//            each fetched byte and flags bus contention.
//            Optional macro BUS_KEEPER_EN enables a registered bus keeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcs4_bus_fabric #(
    parameter int N_ROM = 5,
    parameter int N_RAM = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           cpu_data_o,
    input  logic                 cpu_data_en,
    input  logic [4*N_ROM-1:0]   rom_data_o,
    input  logic [N_ROM-1:0]     rom_data_en,
    input  logic [4*N_RAM-1:0]   ram_data_o,
    input  logic [N_RAM-1:0]     ram_data_en,
    input  logic                 sync,
    input  logic                 clr_err,
    output logic [3:0]           data,
    output logic [2:0]           phase,
    output logic                 phase_valid,
    output logic [7:0]           inst_byte,
    output logic                 inst_valid,
    output logic                 contention,
    output logic [CNT_W-1:0]     contention_cnt,
    output logic                 sync_err
);

    localparam logic [2:0]       c_PH_A1   = 3'd0;
    localparam logic [2:0]       c_PH_M1   = 3'd3;
    localparam logic [2:0]       c_PH_M2   = 3'd4;
    localparam logic [2:0]       c_PH_X3   = 3'd7;
    localparam int               c_EN_W    = $clog2(N_ROM + N_RAM + 2);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        w_drive;
    logic              w_any;
    logic [c_EN_W-1:0] w_en_cnt;
    logic              w_multi;

    logic [2:0]        r_phase;
    logic              r_phase_valid;
    logic [3:0]        r_opr;
    logic              r_opr_ok;
    logic [7:0]        r_inst_byte;
    logic              r_inst_valid;
    logic              r_contention;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sync_err;

    // Lowest priority first so higher-priority drivers overwrite it.
    always_comb begin
        w_drive = 4'h0;
        w_any   = 1'b0;
        for (int j = N_RAM - 1; j >= 0; j--) begin
            if (ram_data_en[j]) begin
                w_drive = ram_data_o[4*j +: 4];
                w_any   = 1'b1;
            end
        end
        for (int i = N_ROM - 1; i >= 0; i--) begin
            if (rom_data_en[i]) begin
                w_drive = rom_data_o[4*i +: 4];
                w_any   = 1'b1;
            end
        end
        if (cpu_data_en) begin
            w_drive = cpu_data_o;
            w_any   = 1'b1;
        end
    end

    always_comb begin
        w_en_cnt = c_EN_W'(cpu_data_en);
        for (int i = 0; i < N_ROM; i++) begin
            w_en_cnt = w_en_cnt + c_EN_W'(rom_data_en[i]);
        end
        for (int j = 0; j < N_RAM; j++) begin
            w_en_cnt = w_en_cnt + c_EN_W'(ram_data_en[j]);
        end
        w_multi = (w_en_cnt > c_EN_W'(1));
    end

`ifdef BUS_KEEPER_EN
    logic [3:0] r_keep;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_keep <= 4'h0;
        end else if (w_any) begin
            r_keep <= w_drive;
        end
    end

    assign data = w_any ? w_drive : r_keep;
`else
    assign data = w_any ? w_drive : 4'h0;
`endif

    // A sync always realigns; it is an error unless the cycle was ending in X3.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= c_PH_A1;
            r_phase_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            if (sync) begin
                r_phase       <= c_PH_A1;
                r_phase_valid <= 1'b1;
            end else if (r_phase_valid) begin
                r_phase <= r_phase + 3'd1;
            end

            if (sync && r_phase_valid && (r_phase != c_PH_X3)) begin
                r_sync_err <= 1'b1;
            end else if (clr_err) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    // A sync clock discards any half-captured instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_opr        <= 4'h0;
            r_opr_ok     <= 1'b0;
            r_inst_byte  <= 8'h00;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            if (sync) begin
                r_opr_ok <= 1'b0;
            end else if (r_phase_valid && (r_phase == c_PH_M1)) begin
                r_opr    <= data;
                r_opr_ok <= 1'b1;
            end else if (r_phase_valid && (r_phase == c_PH_M2)) begin
                r_inst_byte  <= {r_opr, data};
                r_inst_valid <= r_opr_ok;
                r_opr_ok     <= 1'b0;
            end
        end
    end

    // A fresh contention event takes precedence over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contention <= 1'b0;
            r_cnt        <= '0;
        end else if (w_multi) begin
            r_contention <= 1'b1;
            if (clr_err) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (clr_err) begin
            r_contention <= 1'b0;
            r_cnt        <= '0;
        end
    end

    assign phase          = r_phase;
    assign phase_valid    = r_phase_valid;
    assign inst_byte      = r_inst_byte;
    assign inst_valid     = r_inst_valid;
    assign contention     = r_contention;
    assign contention_cnt = r_cnt;
    assign sync_err       = r_sync_err;

endmodule

`default_nettype wire
